// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: operation codes, FSM states, op classification.
package mdu_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide sequencer (slave).
interface mdu_seq_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (output start, op, a, b, input busy, done, hi, lo, div_by_zero);
    modport slave  (input start, op, a, b, output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mdu_seq_ctrl_addsub.sv
// Combinational N-bit adder/subtractor; subtraction is A + ~B + 1, so carry=1 means no borrow.
module mdu_seq_ctrl_addsub #(parameter int N = 33) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);
    logic [N-1:0] b_sel_s;

    // Operand inversion and full-width add with carry-in
    always_comb begin
        b_sel_s            = sub_i ? ~b_i : b_i;
        {carry_o, sum_o}   = {1'b0, a_i} + {1'b0, b_sel_s} + {{N{1'b0}}, sub_i};
    end
endmodule

// File: rtl/mdu_seq_ctrl.sv
// Radix-2 multi-cycle MULT/MULTU/DIV/DIVU sequencer sharing one (WIDTH+1)-bit add/sub datapath.
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mdu_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH:0]   as_a_s, as_b_s, as_sum_s, rem_sh_s;
    logic             as_carry_s, is_div_s, sgn_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;

    // Shared datapath operand selection: divide subtracts the divisor from the shifted remainder
    always_comb begin
        is_div_s = op_is_div(op_q);
        sgn_s    = op_is_signed(op_q);
        rem_sh_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        as_a_s   = is_div_s ? rem_sh_s : {1'b0, acc_hi_q};
        as_b_s   = {1'b0, m_q};
    end

    mdu_seq_ctrl_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i     (as_a_s),
        .b_i     (as_b_s),
        .sub_i   (is_div_s),
        .sum_o   (as_sum_s),
        .carry_o (as_carry_s)
    );

    // Operand magnitudes and sign-corrected results; -2^(W-1) stays as unsigned 2^(W-1)
    always_comb begin
        a_mag_s    = (sgn_s && a_q[WIDTH-1]) ? (~a_q + ONE_W) : a_q;
        b_mag_s    = (sgn_s && b_q[WIDTH-1]) ? (~b_q + ONE_W) : b_q;
        prod_s     = {acc_hi_q, acc_lo_q};
        prod_fix_s = q_neg_q ? (~prod_s + ONE_2W) : prod_s;
        quo_fix_s  = q_neg_q ? (~acc_lo_q + ONE_W) : acc_lo_q;
        rem_fix_s  = r_neg_q ? (~acc_hi_q + ONE_W) : acc_hi_q;
    end

    // Next-state, iteration and result logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_PREP;
                    op_d    = op_e'(bus.op);
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                // Multiply: multiplier in acc_lo, multiplicand in m. Divide: dividend in acc_lo.
                acc_hi_d = {WIDTH{1'b0}};
                acc_lo_d = is_div_s ? a_mag_s : b_mag_s;
                m_d      = is_div_s ? b_mag_s : a_mag_s;
                q_neg_d  = sgn_s && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                r_neg_d  = sgn_s && a_q[WIDTH-1];
                cnt_d    = {CW{1'b0}};
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                if (is_div_s) begin
                    acc_hi_d = as_carry_s ? as_sum_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], as_carry_s};
                end else if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {as_sum_s, acc_lo_q[WIDTH-1:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_FIX: begin
                if (!is_div_s) begin
                    {hi_d, lo_d} = prod_fix_s;
                end else if (b_q == {WIDTH{1'b0}}) begin
                    hi_d  = a_q;
                    lo_d  = {WIDTH{1'b1}};
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIX);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= {CW{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            m_q      <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_seq_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    mdu_seq_ctrl_if #(.WIDTH(32)) bus ();

    mdu_seq_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: begin sp = sa * sb; return {1'b0, sp}; end
            2'b01: begin up = ua * ub; return {1'b0, up}; end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op; optionally hold start high or re-pulse it with junk operands at edges p1/p2
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int p1, input int p2,
                          output int lat, output int bcnt, output logic [64:0] res);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        res  = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = k;
                res = {bus.div_by_zero, bus.hi, bus.lo};
                break;
            end
            if ((k + 1 == p1) || (k + 1 == p2)) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else if (!hold) begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        int lat, bcnt, j2, seen;
        logic [64:0] res, exp;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] corner [4];
        logic [1:0]  d_op [6];
        logic [31:0] d_a [6];
        logic [31:0] d_b [6];
        logic [64:0] d_exp [6];

        total = 0; passed = 0; failed = 0;
        corner[0] = 32'h0; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h1;
        d_op[0] = 2'b01; d_a[0] = 32'hFFFF_FFFF; d_b[0] = 32'hFFFF_FFFF; d_exp[0] = {1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        d_op[1] = 2'b00; d_a[1] = 32'hFFFF_FFFD; d_b[1] = 32'd7;        d_exp[1] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        d_op[2] = 2'b10; d_a[2] = 32'hFFFF_FFF9; d_b[2] = 32'd2;        d_exp[2] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        d_op[3] = 2'b11; d_a[3] = 32'd100;       d_b[3] = 32'd7;        d_exp[3] = {1'b0, 32'd2, 32'd14};
        d_op[4] = 2'b11; d_a[4] = 32'h1234;      d_b[4] = 32'd0;        d_exp[4] = {1'b1, 32'h1234, 32'hFFFF_FFFF};
        d_op[5] = 2'b10; d_a[5] = 32'h8000_0000; d_b[5] = 32'hFFFF_FFFF; d_exp[5] = {1'b0, 32'h0, 32'h8000_0000};

        rst_n = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'h0, bus.busy}, 64'h0);
        check("reset_done", {63'h0, bus.done}, 64'h0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("reset_dbz", {63'h0, bus.div_by_zero}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 1'b0, -1, -1, lat, bcnt, res);
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("dir%0d_busy_cycles", i), 64'(bcnt), 64'd34);
            check($sformatf("dir%0d_hilo", i), res[63:0], d_exp[i][63:0]);
            check($sformatf("dir%0d_dbz", i), {63'h0, res[64]}, {63'h0, d_exp[i][64]});
            @(negedge clk);
            check($sformatf("dir%0d_done_pulse", i), {63'h0, bus.done}, 64'h0);
            check($sformatf("dir%0d_hold", i), {bus.hi, bus.lo}, d_exp[i][63:0]);
        end

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, 1'b0, -1, -1, lat, bcnt, res);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), res[63:0], exp[63:0]);
            check($sformatf("rand%0d_dbz", i), {63'h0, res[64]}, {63'h0, exp[64]});
        end

        exp = model(2'b00, 32'hFFFF_1234, 32'h0000_5678);
        run_op(2'b00, 32'hFFFF_1234, 32'h0000_5678, 1'b0, 5, 20, lat, bcnt, res);
        check("ignored_start_latency", 64'(lat), 64'd34);
        check("ignored_start_result", res[63:0], exp[63:0]);

        exp = model(2'b11, 32'hDEAD_BEEF, 32'h0000_0123);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0123, 1'b1, -1, -1, lat, bcnt, res);
        check("b2b_first_latency", 64'(lat), 64'd34);
        check("b2b_first_result", res[63:0], exp[63:0]);
        j2 = -1;
        for (int j = 1; j < 60; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.start = 1'b0;
                check("b2b_done_pulse", {63'h0, bus.done}, 64'h0);
            end
            if (bus.done) begin
                j2 = j;
                res = {bus.div_by_zero, bus.hi, bus.lo};
                break;
            end
        end
        check("b2b_spacing", 64'(j2), 64'd35);
        check("b2b_second_result", res[63:0], exp[63:0]);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'h7654_3210; bus.b = 32'h0000_0011;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, bus.busy}, 64'h0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'h0);
        exp = model(2'b10, 32'h8765_4321, 32'h0000_0FED);
        run_op(2'b10, 32'h8765_4321, 32'h0000_0FED, 1'b0, -1, -1, lat, bcnt, res);
        check("after_abort_latency", 64'(lat), 64'd34);
        check("after_abort_result", res[63:0], exp[63:0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
